ecg_group_scheduler: RTL and testbench

ECG_GROUP_SCHEDULER -- requirements
Module: ecg_group_scheduler

---
 rtl/ecg_group_scheduler.sv | 123 ++++++++++++
 tb/tb_ecg_group_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ecg_group_scheduler.sv
// Sequences the 12 ECG groups of one block into the encoder and sums their coded sizes.
// Define ECG_SCHED_BACKPRESSURE_EN to let out_ready stall issue; otherwise a block takes 16 cycles.
module ecg_group_scheduler #(
  parameter int MIN_BITS_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            comp_skip_mask,
  input  logic [MIN_BITS_W-1:0] min_block_bits,
  input  logic                  out_ready,
  input  logic                  enc_valid,
  input  logic [5:0]            enc_size,
  output logic                  issue,
  output logic [1:0]            ecgidx,
  output logic [1:0]            component_idx,
  output logic                  component_skip,
  output logic                  underflow_prevention,
  output logic [7:0]            sizeof_stuffing_bits,
  output logic                  busy,
  output logic                  done,
  output logic [MIN_BITS_W-1:0] block_bits,
  output logic                  enc_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, LAST, WAIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              idx, comp;
  logic [2:0]              mask_r;
  logic [MIN_BITS_W-1:0]   min_r, bits;
  logic                    pend, err;
  logic                    rdy;
  logic [MIN_BITS_W:0]     sum;
  logic [MIN_BITS_W-1:0]   sum_sat, gap;

`ifdef ECG_SCHED_BACKPRESSURE_EN
  assign rdy = out_ready;
`else
  assign rdy = out_ready | 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: if (rdy) begin
        issue = 1'b1;
        if (comp == 2'd2 && idx == 2'd2) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = LAST;
      LAST:  if (rdy) begin
        issue     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Group 10's result has landed by LAST, so bits holds the first 11 groups here.
  assign gap                  = min_r - bits;
  assign underflow_prevention = (state == LAST) && rdy && (bits < min_r);
  assign sizeof_stuffing_bits = !underflow_prevention ? 8'd0 :
                                (gap > MIN_BITS_W'(255)) ? 8'hFF : gap[7:0];

  assign sum     = {1'b0, bits} + (MIN_BITS_W+1)'(enc_size);
  assign sum_sat = sum[MIN_BITS_W] ? '1 : sum[MIN_BITS_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      comp   <= '0;
      mask_r <= '0;
      min_r  <= '0;
      bits   <= '0;
      pend   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= issue;
      if (state == IDLE && start) begin
        idx    <= '0;
        comp   <= '0;
        mask_r <= comp_skip_mask;
        min_r  <= min_block_bits;
        bits   <= '0;
        err    <= 1'b0;
      end else begin
        if (pend) begin
          if (enc_valid) bits <= sum_sat;
          else           err  <= 1'b1;
        end
        if (issue) begin
          if (state == LAST) begin
            idx  <= '0;
            comp <= '0;
          end else if (idx == 2'd3) begin
            idx  <= '0;
            comp <= comp + 2'd1;
          end else begin
            idx <= idx + 2'd1;
          end
        end
      end
    end
  end

  assign ecgidx         = idx;
  assign component_idx  = comp;
  assign component_skip = issue & mask_r[comp];
  assign busy           = (state != IDLE);
  assign block_bits     = bits;
  assign enc_err        = err;

endmodule

// File: tb/tb_ecg_group_scheduler.sv
// Directed bench for ecg_group_scheduler: issued groups checked against a scoreboard queue.
module tb_ecg_group_scheduler;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   mask = 3'b000;
  logic [W-1:0] min_bits = '0;
  logic         out_ready = 1'b1;
  logic         enc_valid = 1'b0;
  logic [5:0]   enc_size = '0;
  logic         issue, component_skip, underflow_prevention, busy, done, enc_err;
  logic [1:0]   ecgidx, component_idx;
  logic [7:0]   sizeof_stuffing_bits;
  logic [W-1:0] block_bits;

  logic [5:0]   esize = '0;
  logic         kill5 = 1'b0;
  int           checks = 0;
  int           errors = 0;

  typedef struct packed {logic [1:0] comp; logic [1:0] idx; logic skip;} grp_t;
  grp_t expq[$];

  ecg_group_scheduler #(.MIN_BITS_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .comp_skip_mask(mask),
    .min_block_bits(min_bits), .out_ready(out_ready), .enc_valid(enc_valid),
    .enc_size(enc_size), .issue(issue), .ecgidx(ecgidx),
    .component_idx(component_idx), .component_skip(component_skip),
    .underflow_prevention(underflow_prevention),
    .sizeof_stuffing_bits(sizeof_stuffing_bits), .busy(busy), .done(done),
    .block_bits(block_bits), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  // Encoder stand-in: result one cycle after issue; group 5's result can be dropped.
  always @(posedge clk) begin
    enc_valid <= issue && !(kill5 && {component_idx, ecgidx} == 4'd5);
    enc_size  <= esize;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (issue) begin
      grp_t o, e;
      o = '{component_idx, ecgidx, component_skip};
      if (expq.size() == 0) check("unexpected_issue", int'(o), -1);
      else begin
        e = expq.pop_front();
        check("issued_group", int'(o), int'(e));
      end
    end
  end

  task automatic push_groups(input logic [2:0] m);
    for (int g = 0; g < 12; g++)
      expq.push_back('{2'(g / 4), 2'(g % 4), m[g / 4]});
  endtask

  task automatic run_block(input string name, input logic [2:0] m, input int mn, input int sz,
                           input bit stall, input bit kill, input bit dbl_start,
                           input int exp_dcyc, input int exp_last, input int exp_uf,
                           input int exp_st, input int exp_fin, input int exp_err);
    int dcyc = -1;
    int last_bits = -1, uf = -1, st = -1, fin = -1, err = -1;
    esize = 6'(sz); kill5 = kill; mask = m; min_bits = W'(mn);
    start = 1'b1; out_ready = 1'b1;
    push_groups(m);
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      @(posedge clk); #1;
      start = dbl_start && c == 5;
      if (dbl_start) mask = 3'b111;
      out_ready = !(stall && c >= 3 && c <= 5);
      @(negedge clk);
      if (c == 1) begin
        check({name, "_busy"}, busy, 1);
        check({name, "_err_clr"}, enc_err, 0);
      end
`ifdef ECG_SCHED_BACKPRESSURE_EN
      if (stall && c >= 3 && c <= 5) begin
        check({name, "_stall_issue"}, issue, 0);
        check({name, "_stall_idx"}, ecgidx, 2);
      end
`endif
      if (issue && component_idx == 2'd2 && ecgidx == 2'd3) begin
        last_bits = block_bits; uf = underflow_prevention; st = sizeof_stuffing_bits;
      end
      if (done) begin
        dcyc = c; fin = block_bits; err = enc_err;
      end
    end
    start = 1'b0; out_ready = 1'b1;
    check({name, "_done_cycle"}, dcyc, exp_dcyc);
    check({name, "_last_bits"}, last_bits, exp_last);
    check({name, "_underflow"}, uf, exp_uf);
    check({name, "_stuffing"}, st, exp_st);
    check({name, "_final_bits"}, fin, exp_fin);
    check({name, "_enc_err"}, err, exp_err);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_bits"}, block_bits, exp_fin);
    check({name, "_queue_empty"}, expq.size(), 0);
  endtask

  int stall_done;

  initial begin
`ifdef ECG_SCHED_BACKPRESSURE_EN
    stall_done = 18;
`else
    stall_done = 15;
`endif
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", int'({issue, ecgidx, component_idx, component_skip,
          underflow_prevention, sizeof_stuffing_bits, busy, done, block_bits, enc_err}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_block("basic",  3'b000, 40,  4, 0, 0, 1, 15, 44, 0, 0,   48,  0);
    run_block("stuff255", 3'b000, 300, 1, 0, 0, 0, 15, 11, 1, 255, 12,  0);
    run_block("skipmask", 3'b010, 30,  2, 0, 0, 0, 15, 22, 1, 8,   24,  0);
    run_block("stall",  3'b000, 40,  4, 1, 0, 0, stall_done, 44, 0, 0, 48, 0);
    run_block("drop5",  3'b000, 41,  4, 0, 1, 0, 15, 40, 1, 1,   44,  1);
    run_block("saturate", 3'b101, 500, 63, 0, 0, 0, 15, 511, 0, 0, 511, 0);

    // Reset in the middle of a block, right as group 7 issues.
    esize = 6'd4; kill5 = 1'b0; mask = 3'b000; min_bits = W'(40); start = 1'b1;
    push_groups(3'b000);
    begin
      bit hit = 1'b0;
      for (int c = 1; c <= 20 && !hit; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        if (issue && {component_idx, ecgidx} == 4'd7) hit = 1'b1;
      end
      check("rst_reached_group7", hit, 1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    @(negedge clk);
    check("midblock_reset_outputs", int'({issue, ecgidx, component_idx, component_skip,
          underflow_prevention, sizeof_stuffing_bits, busy, done, block_bits, enc_err}), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("late_result_ignored", block_bits, 0);
    check("late_result_no_err", enc_err, 0);

    run_block("after_rst", 3'b000, 40, 4, 0, 0, 0, 15, 44, 0, 0, 48, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
